led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 120 ++++++++++++
 tb/tb_led_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate, ping-pong and binary-count patterns
// advanced by a prescaled tick, with synchronous load and mode restart.
module led_sequencer #(
  parameter int unsigned      WIDTH  = 5,
  parameter int unsigned      PERIOD = 2097152,
  parameter logic [WIDTH-1:0] INIT   = WIDTH'(1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LEDS,
  output logic             STEP
);

  localparam int unsigned   CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam logic [1:0] M_ROTL = 2'b00;
  localparam logic [1:0] M_ROTR = 2'b01;
  localparam logic [1:0] M_PING = 2'b10;
  localparam logic [1:0] M_CNT  = 2'b11;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_q, step_d;

  logic [WIDTH-1:0] adv_pat;
  logic             adv_dir;
  logic             tick;

  assign tick = EN && (cnt_q == LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      pat_q  <= INIT;
      dir_q  <= DIR_L;
      mode_q <= M_ROTL;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // Pattern the current mode would step to on a tick
  always_comb begin
    adv_pat = pat_q;
    adv_dir = dir_q;
    unique case (mode_q)
      M_ROTL: adv_pat = (pat_q << 1) | (pat_q >> (WIDTH - 1));
      M_ROTR: adv_pat = (pat_q >> 1) | (pat_q << (WIDTH - 1));
      M_CNT:  adv_pat = pat_q + WIDTH'(1);
      M_PING: begin
        if (pat_q == '0) begin
          adv_pat = WIDTH'(1);
          adv_dir = DIR_L;
        end else if (WIDTH == 1) begin
          adv_pat = pat_q;
        end else if (dir_q == DIR_L) begin
          if (pat_q[WIDTH-1]) begin
            adv_pat = pat_q >> 1;
            adv_dir = DIR_R;
          end else begin
            adv_pat = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            adv_pat = pat_q << 1;
            adv_dir = DIR_L;
          end else begin
            adv_pat = pat_q >> 1;
          end
        end
      end
      default: adv_pat = pat_q;
    endcase
  end

  // Load beats mode restart, which beats a tick
  always_comb begin
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = 1'b0;
    if (LOAD) begin
      pat_d  = LOAD_VAL;
      cnt_d  = '0;
      mode_d = MODE;
    end else if (MODE != mode_q) begin
      mode_d = MODE;
      pat_d  = INIT;
      cnt_d  = '0;
      dir_d  = DIR_L;
    end else if (tick) begin
      cnt_d  = '0;
      pat_d  = adv_pat;
      dir_d  = adv_dir;
      step_d = 1'b1;
    end else if (EN) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign LEDS = pat_q;
  assign STEP = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (WIDTH=5, PERIOD=4): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_led_sequencer;

  localparam int W = 5;
  localparam int P = 4;

  logic         CLK;
  logic         RESET;
  logic         EN;
  logic [1:0]   MODE;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] LEDS;
  logic         STEP;

  int vectors;
  int miscompares;

  // reference model state
  int m_pat;
  int m_cnt;
  int m_dir;
  int m_mode;
  bit m_step;

  led_sequencer #(
    .WIDTH (W),
    .PERIOD(P),
    .INIT  (5'b00001)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .MODE    (MODE),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .LEDS    (LEDS),
    .STEP    (STEP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic m_reset();
    m_pat  = 1;
    m_cnt  = 0;
    m_dir  = 0;
    m_mode = 0;
    m_step = 1'b0;
  endtask

  task automatic m_advance();
    case (m_mode)
      0: m_pat = (m_pat * 2) % 32 + m_pat / 16;
      1: m_pat = m_pat / 2 + (m_pat % 2) * 16;
      3: m_pat = (m_pat + 1) % 32;
      default: begin
        if (m_pat == 0) begin
          m_pat = 1;
          m_dir = 0;
        end else if (m_dir == 0) begin
          if (m_pat >= 16) begin
            m_dir = 1;
            m_pat = m_pat / 2;
          end else m_pat = m_pat * 2;
        end else begin
          if (m_pat % 2 == 1) begin
            m_dir = 0;
            m_pat = (m_pat * 2) % 32;
          end else m_pat = m_pat / 2;
        end
      end
    endcase
  endtask

  task automatic m_edge();
    if (RESET) return;
    m_step = 1'b0;
    if (LOAD) begin
      m_pat  = int'(LOAD_VAL);
      m_cnt  = 0;
      m_mode = int'(MODE);
    end else if (int'(MODE) != m_mode) begin
      m_mode = int'(MODE);
      m_pat  = 1;
      m_cnt  = 0;
      m_dir  = 0;
    end else if (EN) begin
      if (m_cnt == P - 1) begin
        m_cnt  = 0;
        m_step = 1'b1;
        m_advance();
      end else m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    m_edge();
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b1; MODE = 2'b00; LOAD = 1'b0; LOAD_VAL = '0;
    m_reset();
    #12;
    vectors++;
    if (LEDS !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_leds: got %b want 00001", LEDS);
    end
    vectors++;
    if (STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_step: got %b want 0", STEP);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got %b/%b want 00001/0", LEDS, STEP);
      end
    end
    #3 RESET = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [W-1:0] exp [6];
    exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    for (int k = 1; k < 6; k++) begin
      for (int c = 1; c <= P; c++) begin
        tick();
        vectors++;
        if (c < P && (LEDS !== exp[k-1] || STEP !== 1'b0)) begin
          miscompares++;
          $display("FAIL rotl_wait: got %b/%b want %b/0", LEDS, STEP, exp[k-1]);
        end
        if (c == P && (LEDS !== exp[k] || STEP !== 1'b1)) begin
          miscompares++;
          $display("FAIL rotl_step: got %b/%b want %b/1", LEDS, STEP, exp[k]);
        end
      end
    end
  endtask

  task automatic test_pingpong();
    logic [W-1:0] exp [9];
    exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
            5'b00100, 5'b00010, 5'b00001, 5'b00010};
    MODE = 2'b10;
    tick();
    vectors++;
    if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL ping_start: got %b/%b want 00001/0", LEDS, STEP);
    end
    for (int k = 0; k < 9; k++) begin
      repeat (P) tick();
      vectors++;
      if (LEDS !== exp[k] || STEP !== 1'b1) begin
        miscompares++;
        $display("FAIL ping_step%0d: got %b/%b want %b/1", k, LEDS, STEP, exp[k]);
      end
    end
    LOAD = 1'b1; LOAD_VAL = 5'b00000;
    tick();
    LOAD = 1'b0;
    vectors++;
    if (LEDS !== 5'b00000 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL ping_load0: got %b/%b want 00000/0", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b00001 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL ping_from0: got %b/%b want 00001/1", LEDS, STEP);
    end
  endtask

  task automatic test_count_load();
    MODE = 2'b11;
    tick();
    LOAD = 1'b1; LOAD_VAL = 5'b11110;
    tick();
    LOAD = 1'b0;
    vectors++;
    if (LEDS !== 5'b11110 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL cnt_load: got %b/%b want 11110/0", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b11111 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL cnt_ones: got %b/%b want 11111/1", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b00000 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL cnt_wrap: got %b/%b want 00000/1", LEDS, STEP);
    end
    MODE = 2'b01; LOAD = 1'b1; LOAD_VAL = 5'b10101;
    tick();
    LOAD = 1'b0;
    vectors++;
    if (LEDS !== 5'b10101 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL rotr_load: got %b/%b want 10101/0", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b11010 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL rotr_step: got %b/%b want 11010/1", LEDS, STEP);
    end
  endtask

  task automatic test_enable_freeze();
    LOAD = 1'b1; LOAD_VAL = 5'b00001;
    tick();
    LOAD = 1'b0;
    repeat (2) tick();
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
        miscompares++;
        $display("FAIL en_freeze: got %b/%b want 00001/0", LEDS, STEP);
      end
    end
    EN = 1'b1;
    tick();
    vectors++;
    if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL en_resume1: got %b/%b want 00001/0", LEDS, STEP);
    end
    tick();
    vectors++;
    if (LEDS !== 5'b10000 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL en_resume2: got %b/%b want 10000/1", LEDS, STEP);
    end
  endtask

  task automatic test_mode_change_tick();
    MODE = 2'b00; LOAD = 1'b1; LOAD_VAL = 5'b00100;
    tick();
    LOAD = 1'b0;
    repeat (P - 1) tick();
    MODE = 2'b01;
    tick();
    vectors++;
    if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL mchg_tick: got %b/%b want 00001/0", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b10000 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL mchg_next: got %b/%b want 10000/1", LEDS, STEP);
    end
    repeat (P - 1) tick();
    MODE = 2'b00; LOAD = 1'b1; LOAD_VAL = 5'b01011;
    tick();
    LOAD = 1'b0;
    vectors++;
    if (LEDS !== 5'b01011 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL mchg_load: got %b/%b want 01011/0", LEDS, STEP);
    end
    repeat (P) tick();
    vectors++;
    if (LEDS !== 5'b10110 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL mchg_load_next: got %b/%b want 10110/1", LEDS, STEP);
    end
  endtask

  task automatic test_async_reset();
    MODE = 2'b10;
    tick();
    repeat (5 * P + 2) tick();
    vectors++;
    if (LEDS !== 5'b01000) begin
      miscompares++;
      $display("FAIL arst_pre: got %b want 01000", LEDS);
    end
    #2 RESET = 1'b1;
    m_reset();
    #1;
    vectors++;
    if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_now: got %b/%b want 00001/0", LEDS, STEP);
    end
    tick();
    #3 RESET = 1'b0;
    for (int c = 0; c < P; c++) begin
      tick();
      vectors++;
      if (LEDS !== 5'b00001 || STEP !== 1'b0) begin
        miscompares++;
        $display("FAIL arst_release: got %b/%b want 00001/0", LEDS, STEP);
      end
    end
    tick();
    vectors++;
    if (LEDS !== 5'b00010 || STEP !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_first: got %b/%b want 00010/1", LEDS, STEP);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      EN   = ($urandom_range(0, 5) != 0);
      LOAD = ($urandom_range(0, 19) == 0);
      LOAD_VAL = W'($urandom_range(0, 31));
      if ($urandom_range(0, 24) == 0) MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        #2 RESET = 1'b1;
        m_reset();
        #2 RESET = 1'b0;
      end
      tick();
      vectors++;
      if (LEDS !== W'(m_pat) || STEP !== m_step) begin
        miscompares++;
        $display("FAIL rand_cycle%0d: got %b/%b want %b/%b",
                 i, LEDS, STEP, W'(m_pat), m_step);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_rotate_left();
    test_pingpong();
    test_count_load();
    test_enable_freeze();
    test_mode_change_tick();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
